reg_control_pipe: RTL and testbench
===================================

Name: reg_control_pipe

Overview:
Pipeline register for decoded control signals in the vector CPU, sitting between the decode stage and the execute/memory stages. It captures the control bundle (ALU/memory/shift/writeback controls) on the rising clock edge when enabled, and holds it otherwise. It has one-cycle latency and no combinational path from d_* to q_*.

Parameters:
MEM_OP_W, 2, width of memory-operation code
ESC_WR_W, 2, width of scalar register-write control
VEC_WR_W, 2, width of vector register-write control
ALU_OP_W, 4, width of ALU operation code

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset; asynchronous, active-low
en  input  1  capture enable; 1 = load d_*, 0 = hold q_*
d_cl_alu_st  input  1  ALU-stage select
d_cl_mem_st  input  1  memory-stage select
d_cl_shift_op  input  1  shift operation flag
d_cl_mem_op  input  MEM_OP_W  memory op code
d_cl_esc_wr  input  ESC_WR_W  scalar register write control
d_cl_vec_wr  input  VEC_WR_W  vector register write control
d_cl_alu_op  input  ALU_OP_W  ALU op code
q_cl_alu_st, q_cl_mem_st, q_cl_shift_op, q_cl_mem_op, q_cl_esc_wr, q_cl_vec_wr, q_cl_alu_op  output  same widths as matching d_*  registered copies
(flush  input  1  present only with REG_CONTROL_FLUSH_EN; see below)

Behaviour:
- rst_n low: all q_* cleared to 0 immediately, independent of clk. All-zero is the NOP bubble: no stores, no register writes, ALU op 0.
- Reset release: takes effect on the first rising clk edge after rst_n goes high; no capture occurs on an edge where rst_n is low.
- Rising clk with en=1: every q_* takes the value of the matching d_* in the same edge. Latency is 1 cycle.
- Rising clk with en=0: every q_* holds its value. d_* changes have no effect.
- All fields share the single en; no per-field enables.
- Outputs are driven directly from flops; no glitches from d_* changes between edges.
- X on d_* with en=0: no effect on q_*.

Optional Feature:
REG_CONTROL_FLUSH_EN: when defined, adds the input flush. On a rising clk with flush=1, all q_* load 0 (NOP bubble), regardless of en. Flush has priority over en, and async reset has priority over both. When the macro is undefined, the flush port does not exist and behaviour is exactly as in Behaviour above.

Decomposition:
- Shared package ctrl_pkg holds the width localparams (MEM_OP_W, ESC_WR_W, VEC_WR_W, ALU_OP_W).
- ctrl_pkg also holds a packed struct ctrl_t bundling the seven fields, plus the constant CTRL_NOP = '0.
- One natural sub-module: en_dff, a parameterized-width flop with enable and async active-low reset, instantiated once per field or once on the packed ctrl_t.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with nonzero q_* -> all q_* read 0 before the next edge; they stay 0 until rst_n=1 and an enabled edge.
- Normal capture: en=1, d = {alu_st=1, mem_st=1, shift_op=0, mem_op=2, esc_wr=2, vec_wr=1, alu_op=3}, one edge -> q_* equal those values.
- Hold: after the normal-capture case, set en=0, d = {0, 0, 1, 3, 3, 0, 4}, apply several edges -> q_* remain {1, 1, 0, 2, 2, 1, 3}.
- Re-enable: en=1 with d = {0, 0, 1, 3, 3, 0, 4} -> q_* = {0, 0, 1, 3, 3, 0, 4} after one edge, and not before that edge.
- Back-to-back: en=1, change d every cycle (alu_op 0..15) -> q_cl_alu_op tracks with exactly one cycle of delay.
- With REG_CONTROL_FLUSH_EN: q_* nonzero, flush=1 with en=0 -> all q_* become 0 after one edge. With flush=1, en=1 and d nonzero -> q_* still 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared widths and the packed control bundle carried by the decode-to-execute
// pipeline register. CTRL_NOP is the all-zero bubble.
package ctrl_pkg;

    localparam int MEM_OP_W = 2;
    localparam int ESC_WR_W = 2;
    localparam int VEC_WR_W = 2;
    localparam int ALU_OP_W = 4;

    typedef struct packed {
        logic                alu_st;
        logic                mem_st;
        logic                shift_op;
        logic [MEM_OP_W-1:0] mem_op;
        logic [ESC_WR_W-1:0] esc_wr;
        logic [VEC_WR_W-1:0] vec_wr;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/reg_control_pipe_en_dff.sv
// Parameterized-width register with load enable and asynchronous active-low
// clear; used to hold the whole packed control bundle.
module en_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the hold case needs no else branch in a clocked block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_control_pipe.sv
// Decode-to-execute pipeline register for the control bundle: one-cycle latency,
// shared enable. Optional synchronous bubble insertion via REG_CONTROL_FLUSH_EN.
module reg_control_pipe
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
`ifdef REG_CONTROL_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                d_cl_alu_st,
    input  logic                d_cl_mem_st,
    input  logic                d_cl_shift_op,
    input  logic [MEM_OP_W-1:0] d_cl_mem_op,
    input  logic [ESC_WR_W-1:0] d_cl_esc_wr,
    input  logic [VEC_WR_W-1:0] d_cl_vec_wr,
    input  logic [ALU_OP_W-1:0] d_cl_alu_op,
    output logic                q_cl_alu_st,
    output logic                q_cl_mem_st,
    output logic                q_cl_shift_op,
    output logic [MEM_OP_W-1:0] q_cl_mem_op,
    output logic [ESC_WR_W-1:0] q_cl_esc_wr,
    output logic [VEC_WR_W-1:0] q_cl_vec_wr,
    output logic [ALU_OP_W-1:0] q_cl_alu_op
);

    ctrl_t d_bus;
    ctrl_t next_bus;
    ctrl_t q_bus;
    logic  load;

    assign d_bus = '{
        alu_st:   d_cl_alu_st,
        mem_st:   d_cl_mem_st,
        shift_op: d_cl_shift_op,
        mem_op:   d_cl_mem_op,
        esc_wr:   d_cl_esc_wr,
        vec_wr:   d_cl_vec_wr,
        alu_op:   d_cl_alu_op
    };

`ifdef REG_CONTROL_FLUSH_EN
    // Flush forces a load of the bubble, overriding en.
    assign load     = en | flush;
    assign next_bus = flush ? CTRL_NOP : d_bus;
`else
    assign load     = en;
    assign next_bus = d_bus;
`endif

    en_dff #(
        .W($bits(ctrl_t))
    ) u_ctrl_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .d     (next_bus),
        .q     (q_bus)
    );

    assign q_cl_alu_st   = q_bus.alu_st;
    assign q_cl_mem_st   = q_bus.mem_st;
    assign q_cl_shift_op = q_bus.shift_op;
    assign q_cl_mem_op   = q_bus.mem_op;
    assign q_cl_esc_wr   = q_bus.esc_wr;
    assign q_cl_vec_wr   = q_bus.vec_wr;
    assign q_cl_alu_op   = q_bus.alu_op;

endmodule

// File: tb/tb_reg_control_pipe.sv
// Self-checking bench for reg_control_pipe: directed table, reset/latency
// sequences and randomized traffic against a last-captured-value model.
module tb_reg_control_pipe;
    import ctrl_pkg::*;

`ifdef REG_CONTROL_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    localparam ctrl_t C_A    = '{1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 2'd1, 4'd3};
    localparam ctrl_t C_B    = '{1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd0, 4'd4};
    localparam ctrl_t C_ONES = '1;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                flush;
    logic                d_cl_alu_st, d_cl_mem_st, d_cl_shift_op;
    logic [MEM_OP_W-1:0] d_cl_mem_op;
    logic [ESC_WR_W-1:0] d_cl_esc_wr;
    logic [VEC_WR_W-1:0] d_cl_vec_wr;
    logic [ALU_OP_W-1:0] d_cl_alu_op;
    logic                q_cl_alu_st, q_cl_mem_st, q_cl_shift_op;
    logic [MEM_OP_W-1:0] q_cl_mem_op;
    logic [ESC_WR_W-1:0] q_cl_esc_wr;
    logic [VEC_WR_W-1:0] q_cl_vec_wr;
    logic [ALU_OP_W-1:0] q_cl_alu_op;

    int    n_tests;
    int    n_fail;
    ctrl_t model_q;

    reg_control_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
`ifdef REG_CONTROL_FLUSH_EN
        .flush         (flush),
`endif
        .d_cl_alu_st   (d_cl_alu_st),
        .d_cl_mem_st   (d_cl_mem_st),
        .d_cl_shift_op (d_cl_shift_op),
        .d_cl_mem_op   (d_cl_mem_op),
        .d_cl_esc_wr   (d_cl_esc_wr),
        .d_cl_vec_wr   (d_cl_vec_wr),
        .d_cl_alu_op   (d_cl_alu_op),
        .q_cl_alu_st   (q_cl_alu_st),
        .q_cl_mem_st   (q_cl_mem_st),
        .q_cl_shift_op (q_cl_shift_op),
        .q_cl_mem_op   (q_cl_mem_op),
        .q_cl_esc_wr   (q_cl_esc_wr),
        .q_cl_vec_wr   (q_cl_vec_wr),
        .q_cl_alu_op   (q_cl_alu_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic  en;
        ctrl_t d;
        ctrl_t q;
        string name;
    } vec_t;

    function automatic ctrl_t get_q();
        ctrl_t r;
        r = '{q_cl_alu_st, q_cl_mem_st, q_cl_shift_op, q_cl_mem_op,
              q_cl_esc_wr, q_cl_vec_wr, q_cl_alu_op};
        return r;
    endfunction

    task automatic drive(input ctrl_t v);
        d_cl_alu_st   = v.alu_st;
        d_cl_mem_st   = v.mem_st;
        d_cl_shift_op = v.shift_op;
        d_cl_mem_op   = v.mem_op;
        d_cl_esc_wr   = v.esc_wr;
        d_cl_vec_wr   = v.vec_wr;
        d_cl_alu_op   = v.alu_op;
    endtask

    task automatic check(input string name, input ctrl_t act, input ctrl_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: apply inputs, confirm outputs have not moved
    // before the rising edge, then advance the model across that edge.
    task automatic cycle(input logic e, input ctrl_t v, input logic f);
        en    = e;
        flush = f;
        drive(v);
        #1;
        check("pre_edge_hold", get_q(), model_q);
        @(posedge clk);
        if (rst_n) begin
            if (HAS_FLUSH && f) model_q = CTRL_NOP;
            else if (e)         model_q = v;
        end
        @(negedge clk);
    endtask

    vec_t tbl[7];

    initial begin
        ctrl_t v;
        n_tests = 0;
        n_fail  = 0;
        model_q = CTRL_NOP;

        tbl[0] = '{1'b1, C_A,    C_A,    "capture"};
        tbl[1] = '{1'b0, C_B,    C_A,    "hold_1"};
        tbl[2] = '{1'b0, C_B,    C_A,    "hold_2"};
        tbl[3] = '{1'b0, C_B,    C_A,    "hold_3"};
        tbl[4] = '{1'b1, C_B,    C_B,    "reenable"};
        tbl[5] = '{1'b1, C_ONES, C_ONES, "all_ones"};
        tbl[6] = '{1'b0, CTRL_NOP, C_ONES, "hold_ones"};

        // Power-on reset with enabled edges while rst_n is low.
        rst_n = 1'b0;
        en    = 1'b1;
        flush = 1'b0;
        drive(C_ONES);
        #1;
        check("reset_initial", get_q(), CTRL_NOP);
        @(negedge clk);
        check("reset_no_capture_1", get_q(), CTRL_NOP);
        @(negedge clk);
        check("reset_no_capture_2", get_q(), CTRL_NOP);
        rst_n = 1'b1;
        en    = 1'b0;

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].en, tbl[i].d, 1'b0);
            check(tbl[i].name, get_q(), tbl[i].q);
        end

        // Asynchronous reset mid-cycle with nonzero outputs.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", get_q(), CTRL_NOP);
        model_q = CTRL_NOP;
        @(negedge clk);
        cycle(1'b1, C_ONES, 1'b0);
        check("reset_held_en", get_q(), CTRL_NOP);
        rst_n = 1'b1;
        cycle(1'b0, C_A, 1'b0);
        check("reset_release_hold", get_q(), CTRL_NOP);
        cycle(1'b1, C_A, 1'b0);
        check("reset_release_capture", get_q(), C_A);

        // Back-to-back capture: alu_op follows with one cycle of delay.
        for (int i = 0; i < 16; i++) begin
            v        = C_B;
            v.alu_op = 4'(i);
            cycle(1'b1, v, 1'b0);
            check("b2b_alu_op", get_q(), v);
        end

`ifdef REG_CONTROL_FLUSH_EN
        cycle(1'b1, C_ONES, 1'b0);
        check("flush_setup", get_q(), C_ONES);
        cycle(1'b0, C_A, 1'b1);
        check("flush_en0", get_q(), CTRL_NOP);
        cycle(1'b1, C_ONES, 1'b1);
        check("flush_over_en", get_q(), CTRL_NOP);
        cycle(1'b1, C_ONES, 1'b0);
        check("flush_release", get_q(), C_ONES);
`endif

        // Randomized traffic including occasional async reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                #1;
                model_q = CTRL_NOP;
                check("rand_reset", get_q(), CTRL_NOP);
                cycle(1'($urandom), ctrl_t'(13'($urandom)), 1'b0);
                rst_n = 1'b1;
            end
            v = ctrl_t'(13'($urandom));
            cycle(1'($urandom), v, HAS_FLUSH && ($urandom_range(0, 7) == 0));
            check("rand", get_q(), model_q);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
